// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB-first, start/busy/done handshake.
// Optional signed-overflow output OVF is enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             OVF,
`endif
  output logic             BORROW
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic a0, b0, d_bit, br_nxt;

  // Full-subtractor cell on the current LSBs with the registered borrow.
  always_comb begin
    a0     = a_q[0];
    b0     = b_q[0];
    d_bit  = a0 ^ b0 ^ br_q;
    br_nxt = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          work_d  = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        work_d = {d_bit, work_q[WIDTH-1:1]};
        br_d   = br_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // The MSB step: publish the result and return to IDLE in the same edge.
          cnt_d    = '0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          diff_d   = work_d;
          borrow_d = br_nxt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          ovf_d    = (a0 ^ b0) & (a0 ^ d_bit);
`endif
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign DIFF   = diff_q;
  assign BORROW = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign OVF    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         START = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         BUSY, DONE, BORROW;
  logic [W-1:0] DIFF;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         OVF;
`endif

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .DIFF(DIFF),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .OVF(OVF),
`endif
    .BORROW(BORROW)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted request completes WIDTH edges later.
  logic         m_busy = 1'b0, m_done = 1'b0, m_borrow = 1'b0, m_ovf = 1'b0;
  logic [W-1:0] m_diff = '0, m_a = '0, m_b = '0;
  int           m_left = 0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_busy = 1'b0; m_done = 1'b0; m_diff = '0; m_borrow = 1'b0; m_ovf = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          int sa, sb, sd;
          sa = int'($signed(m_a));
          sb = int'($signed(m_b));
          sd = sa - sb;
          m_busy   = 1'b0;
          m_done   = 1'b1;
          m_diff   = W'((int'(m_a) - int'(m_b)) & ((1 << W) - 1));
          m_borrow = (m_a < m_b);
          m_ovf    = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
        end
      end else if (START) begin
        m_a = A; m_b = B; m_busy = 1'b1; m_left = W;
      end
    end
  end

  always @(negedge CLK) begin
    chk("busy", BUSY, m_busy);
    chk("done", DONE, m_done);
    chk("diff", DIFF, m_diff);
    chk("borrow", BORROW, m_borrow);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("ovf", OVF, m_ovf);
`endif
  end

  // One operation; checks latency, busy length and the hand-computed result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ed, input logic eb, input string tag);
    int n, busy_n;
    @(posedge CLK); #1;
    A = a; B = b; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; A = '0; B = '0;
    n = 0; busy_n = 0;
    forever begin
      @(negedge CLK);
      if (BUSY) busy_n++;
      if (DONE || n >= 20) break;
      @(posedge CLK);
      n++;
    end
    chk({tag, "_latency"}, n, 8);
    chk({tag, "_busy_cycles"}, busy_n, 8);
    chk({tag, "_diff"}, DIFF, ed);
    chk({tag, "_borrow"}, BORROW, eb);
    chk({tag, "_model_diff"}, m_diff, ed);
  endtask

  initial begin
    int n, dones;
    repeat (2) @(negedge CLK);
    chk("reset_busy", BUSY, 0);
    chk("reset_done", DONE, 0);
    chk("reset_diff", DIFF, 0);
    @(posedge CLK); #1 RST_N = 1'b1;

    run_op(8'h05, 8'h03, 8'h02, 1'b0, "op_05_03");
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("ovf_05_03", OVF, 0);
`endif
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, "op_03_05");
    run_op(8'h00, 8'hFF, 8'h01, 1'b1, "op_00_FF");
    run_op(8'hAA, 8'hAA, 8'h00, 1'b0, "op_AA_AA");
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, "op_80_01");
    chk("ovf_80_01", OVF, 1);
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, "op_7F_FF");
    chk("ovf_7F_FF", OVF, 1);
`endif

    // START during RUN is ignored; START in the DONE cycle is accepted.
    @(posedge CLK); #1;
    A = 8'h10; B = 8'h01; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge CLK);
    #1 A = 8'hFF; B = 8'h00; START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    n = 4;
    forever begin
      @(negedge CLK);
      if (DONE || n >= 20) break;
      @(posedge CLK);
      n++;
    end
    chk("ign_latency", n, 8);
    chk("ign_diff", DIFF, 8'h0F);
    A = 8'h20; B = 8'h07; START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    n = 0;
    forever begin
      @(negedge CLK);
      if (DONE || n >= 20) break;
      @(posedge CLK);
      n++;
    end
    chk("b2b_latency", n, 8);
    chk("b2b_diff", DIFF, 8'h19);

    // START held high: a new operation every WIDTH+1 edges.
    @(posedge CLK); #1;
    A = 8'hC8; B = 8'h64; START = 1'b1;
    dones = 0;
    repeat (28) begin
      @(posedge CLK);
      @(negedge CLK);
      if (DONE) dones++;
    end
    START = 1'b0;
    chk("hold_dones", dones, 3);
    chk("hold_diff", DIFF, 8'h64);
    repeat (12) @(posedge CLK);

    // Reset mid-RUN aborts without DONE.
    @(posedge CLK); #1;
    A = 8'h33; B = 8'h11; START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    repeat (4) @(posedge CLK);
    #1 RST_N = 1'b0;
    #1;
    chk("rst_busy", BUSY, 0);
    chk("rst_diff", DIFF, 0);
    chk("rst_done", DONE, 0);
    repeat (2) begin
      @(negedge CLK);
      chk("rst_no_done", DONE, 0);
    end
    @(posedge CLK); #1 RST_N = 1'b1;
    run_op(8'h09, 8'h04, 8'h05, 1'b0, "op_09_04");

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
